// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - direct-mapped read-only instruction cache with line-fill FSM (optional stats: ICACHE_STATS_EN)
module instr_cache #(
  parameter int          LINE_WORDS = 8,
  parameter int          NUM_SETS   = 32,
  parameter logic [15:0] NOP_WORD   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        rd_en,
  input  logic        flush,
  output logic [15:0] instr,
  output logic        stall,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt,
  output logic [15:0] stall_cnt
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 16 - 1 - OFF_W - IDX_W;
  localparam int CNT_W = OFF_W + 1;
  localparam logic [OFF_W-1:0] LAST_WORD  = OFF_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] ISSUE_DONE = CNT_W'(LINE_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [15:0]       r_data [NUM_SETS][LINE_WORDS];
  logic [TAG_W-1:0]  r_tag  [NUM_SETS];
  logic [NUM_SETS-1:0] r_valid;

  logic [15:0]       r_miss_addr;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [OFF_W-1:0]  r_ret_cnt;

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_miss_idx;
  logic [TAG_W-1:0]  w_miss_tag;
  logic              w_hit;
  logic              w_start_miss;
  logic              w_issue_active;
  logic              w_ret_write;
  logic              w_last_ret;
  logic              w_fill_done;
  logic              w_unused_pc0;

  // Byte-address split of the fetch PC and of the latched miss line base.
  assign w_off        = pc[OFF_W:1];
  assign w_idx        = pc[OFF_W+IDX_W:OFF_W+1];
  assign w_tag        = pc[15:OFF_W+IDX_W+1];
  assign w_miss_idx   = r_miss_addr[OFF_W+IDX_W:OFF_W+1];
  assign w_miss_tag   = r_miss_addr[15:OFF_W+IDX_W+1];
  assign w_unused_pc0 = pc[0];

  // Lookup only happens in IDLE; during a fill every fetch is stalled.
  assign w_hit = rd_en & r_valid[w_idx] & (r_tag[w_idx] == w_tag) & (r_state == S_IDLE);

  // A flush in the same cycle as a miss wins: no fill is started.
  assign w_start_miss   = (r_state == S_IDLE) & rd_en & ~w_hit & ~flush;
  assign w_issue_active = (r_state != S_IDLE) & (r_issue_cnt != ISSUE_DONE);
  assign w_ret_write    = (r_state != S_IDLE) & mem_rvalid;
  assign w_last_ret     = w_ret_write & (r_ret_cnt == LAST_WORD);
  // A flush landing on the final return still leaves the line invalid.
  assign w_fill_done    = (r_state == S_FILL) & w_last_ret & ~flush;

  // Next-state logic and combinational fetch/memory outputs.
  always_comb begin
    w_next_state = r_state;
    instr        = NOP_WORD;
    stall        = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = 16'h0000;

    if (w_hit) begin
      instr = r_data[w_idx][w_off];
    end
    stall = rd_en & ~w_hit;

    if (w_issue_active) begin
      mem_req  = 1'b1;
      mem_addr = r_miss_addr + 16'({r_issue_cnt[OFF_W-1:0], 1'b0});
    end

    case (r_state)
      S_IDLE: begin
        if (w_start_miss) begin
          w_next_state = S_FILL;
        end
      end
      S_FILL: begin
        if (w_last_ret) begin
          w_next_state = S_IDLE;
        end else if (flush) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_last_ret) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Miss base address plus issue/return counters for the line fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_addr <= 16'h0000;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
    end else if (w_start_miss) begin
      r_miss_addr <= {pc[15:OFF_W+1], {(OFF_W+1){1'b0}}};
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
    end else begin
      if (w_issue_active) begin
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      end
      if (w_ret_write) begin
        r_ret_cnt <= r_ret_cnt + OFF_W'(1);
      end
    end
  end

  // Valid bits: cleared by flush, cleared for the victim at miss, set when the fill completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      if (w_start_miss) begin
        r_valid[w_idx] <= 1'b0;
      end
      if (w_fill_done) begin
        r_valid[w_miss_idx] <= 1'b1;
      end
    end
  end

  // Data and tag arrays are not reset; valid bits guard their use.
  always_ff @(posedge clk) begin
    if (w_ret_write) begin
      r_data[w_miss_idx][r_ret_cnt] <= mem_rdata;
    end
    if (w_fill_done) begin
      r_tag[w_miss_idx] <= w_miss_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;
  logic [15:0] r_stall_cnt;

  // Saturating event counters; flush clears them alongside the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt   <= 16'h0000;
      r_miss_cnt  <= 16'h0000;
      r_stall_cnt <= 16'h0000;
    end else if (flush) begin
      r_hit_cnt   <= 16'h0000;
      r_miss_cnt  <= 16'h0000;
      r_stall_cnt <= 16'h0000;
    end else begin
      if (w_hit && (r_hit_cnt != 16'hFFFF)) begin
        r_hit_cnt <= r_hit_cnt + 16'd1;
      end
      if (w_start_miss && (r_miss_cnt != 16'hFFFF)) begin
        r_miss_cnt <= r_miss_cnt + 16'd1;
      end
      if (stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_instr_cache.sv
// tb/tb_instr_cache.sv - scoreboard testbench for instr_cache with randomized fetch stream
module tb_instr_cache;

  localparam int NS = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic        rd_en;
  logic        flush;
  logic [15:0] instr;
  logic        stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  logic [15:0] stall_cnt;
`endif

  instr_cache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .rd_en      (rd_en),
    .flush      (flush),
    .instr      (instr),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] req_q [$];
  logic [15:0] data_q [$];

  bit          m_valid [NS];
  int          m_tag   [NS];

  typedef struct {
    logic [15:0] addr;
    int          due;
  } pend_t;
  pend_t pend [$];
  int    cyc = 0;
  int    last_due = 0;
  int    lat_fixed = 3;
  int    spur_req = 0;
  int    spur_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] word_at(input logic [15:0] a);
    return 16'hA000 + 16'(a >> 1);
  endfunction

  // Memory: in-order returns, latency fixed or random, at most one return per cycle.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
        last_due = 0;
      end else if (mem_req) begin
        pend_t p;
        int lat;
        lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
        p.addr = mem_addr;
        p.due  = cyc + lat;
        if (p.due <= last_due) p.due = last_due + 1;
        last_due = p.due;
        pend.push_back(p);
      end
      @(posedge clk);
      #1;
      cyc++;
      mem_rvalid = 1'b0;
      mem_rdata  = 16'h0000;
      if (rst_n && pend.size() != 0 && pend[0].due <= cyc) begin
        pend_t p;
        p = pend.pop_front();
        mem_rvalid = 1'b1;
        mem_rdata  = word_at(p.addr);
      end else if (spur_done != spur_req) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hDEAD;
        spur_done++;
      end
    end
  end

  // Request monitor: every issued request must match the next expected address.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_req) begin
          if (req_q.size() == 0) begin
            n_total++;
            $display("FAIL mem_req_unexpected: got addr %h want no request at %0t", mem_addr, $time);
          end else begin
            check("mem_addr", 32'(mem_addr), 32'(req_q.pop_front()));
          end
        end else begin
          check("mem_addr_idle", 32'(mem_addr), 32'h0);
        end
      end
    end
  end

  // Fetch monitor: every accepted fetch must return the expected instruction.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rd_en && !stall) begin
        if (data_q.size() == 0) begin
          n_total++;
          $display("FAIL fetch_unexpected: got instr %h want no fetch at %0t", instr, $time);
        end else begin
          check("instr", 32'(instr), 32'(data_q.pop_front()));
        end
      end
    end
  end

  task automatic push_line_reqs(input logic [15:0] a);
    logic [15:0] base;
    base = a & 16'hFFF0;
    for (int i = 0; i < 8; i++) req_q.push_back(base + 16'(2 * i));
  endtask

  task automatic fetch(input logic [15:0] a, input bit flush_mid);
    int  idx;
    int  tg;
    bit  hit;
    bit  do_flush_mid;
    bit  flushed;
    int  nreq;
    int  n;
    idx = (int'(a) / 16) % NS;
    tg  = int'(a) / 512;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    do_flush_mid = flush_mid && !hit;
    flushed = 1'b0;
    nreq = 0;
    n = 0;
    if (!hit) push_line_reqs(a);
    if (do_flush_mid) begin
      push_line_reqs(a);
      for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
    end
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    data_q.push_back(word_at(a));
    pc    = a;
    rd_en = 1'b1;
    @(negedge clk);
    check(hit ? "stall_on_hit" : "stall_on_miss", 32'(stall), 32'(!hit));
    while (stall && n < 300) begin
      if (mem_req) nreq++;
      if (do_flush_mid && !flushed && nreq == 2) begin
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        flushed = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    check("fetch_completes", 32'(stall), 32'h0);
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  task automatic flush_idle();
    rd_en = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nreq;
    rst_n = 1'b0;
    pc    = 16'h0000;
    rd_en = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
    end
    repeat (2) @(negedge clk);
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_instr", 32'(instr), 32'h0);
    check("reset_mem_req", 32'(mem_req), 32'h0);
    rd_en = 1'b1;
    #1 check("reset_stall_rd", 32'(stall), 32'h1);
    rd_en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Cold miss then hits across the same line.
    lat_fixed = 3;
    for (int i = 0; i < 8; i++) fetch(16'(2 * i), 1'b0);
    // Conflict eviction at index 0 and back.
    fetch(16'h0200, 1'b0);
    fetch(16'h0000, 1'b0);
    // Flush one cycle after the second request of a fill.
    fetch(16'h0010, 1'b1);
    fetch(16'h0012, 1'b0);

    // Disabled fetch on a cold address plus a spurious return while idle.
    pc = 16'h1230;
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rd_en0_stall", 32'(stall), 32'h0);
      check("rd_en0_instr", 32'(instr), 32'h0);
      check("rd_en0_mem_req", 32'(mem_req), 32'h0);
    end
    spur_req++;
    repeat (3) @(posedge clk);
    #1;
    fetch(16'h0014, 1'b0);
    fetch(16'h1230, 1'b0);

    // Reset in the middle of a fill.
    flush_idle();
    push_line_reqs(16'h0000);
    pc = 16'h0000;
    rd_en = 1'b1;
    nreq = 0;
    for (int n = 0; n < 50 && nreq < 3; n++) begin
      @(negedge clk);
      if (mem_req) nreq++;
    end
    check("reset_fill_started", 32'(nreq), 32'd3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    rd_en = 1'b0;
    #1;
    check("reset_mid_mem_req", 32'(mem_req), 32'h0);
    check("reset_mid_mem_addr", 32'(mem_addr), 32'h0);
    check("reset_mid_stall", 32'(stall), 32'h0);
    req_q.delete();
    for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
`ifdef ICACHE_STATS_EN
    check("stats_hit_reset", 32'(hit_cnt), 32'h0);
    check("stats_miss_reset", 32'(miss_cnt), 32'h0);
    check("stats_stall_reset", 32'(stall_cnt), 32'h0);
`endif
    for (int i = 0; i < 8; i++) fetch(16'(2 * i), 1'b0);
`ifdef ICACHE_STATS_EN
    check("stats_hit", 32'(hit_cnt), 32'd8);
    check("stats_miss", 32'(miss_cnt), 32'd1);
`endif

    // Random fetch stream over a few sets and tags, with occasional flushes.
    lat_fixed = 0;
    for (int k = 0; k < 200; k++) begin
      int r;
      logic [15:0] a;
      r = int'($urandom_range(0, 19));
      a = 16'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 7) << 1));
      if (r == 0) flush_idle();
      else fetch(a, r == 1);
    end

    repeat (4) @(posedge clk);
    check("data_q_empty", 32'(data_q.size()), 32'h0);
    check("req_q_empty", 32'(req_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
